pcileech_led_ctl: RTL and testbench

- Parametrised multi-channel LED status/activity controller for board top modules.
- Replaces the per-board ad-hoc LED drive (PCIe state, COM tx-data activity, ETH red/green state) with one block.
- NUM_CH channels, each with a runtime-selectable mode: off, on, activity-stretch or blink.
- Sits in the top level between the status/activity sources (pcie, com, eth) and the LED pins; single clock domain.

---
 rtl/pcileech_led_ctl_if.sv | 18 +
 rtl/pcileech_led_ctl.sv | 182 ++++++++++++++++++
 tb/tb_pcileech_led_ctl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pcileech_led_ctl_if.sv
// Status/activity bus between the board top level and pcileech_led_ctl.
// PCILEECH_LED_CTL_PWM_EN adds the brightness input used for PWM dimming.
interface pcileech_led_ctl_if #(
    parameter int unsigned NUM_CH = 6
);
    logic [2*NUM_CH-1:0] mode;
    logic [NUM_CH-1:0]   act;
    logic [NUM_CH-1:0]   led;
`ifdef PCILEECH_LED_CTL_PWM_EN
    logic [7:0]          brightness;

    modport master (output mode, output act, output brightness, input led);
    modport slave  (input mode, input act, input brightness, output led);
`else
    modport master (output mode, output act, input led);
    modport slave  (input mode, input act, output led);
`endif
endinterface

// File: rtl/pcileech_led_ctl.sv
// Multi-channel LED controller: per-channel OFF / ON / ACTIVITY-stretch / BLINK modes.
// Optional PWM dimming via macro PCILEECH_LED_CTL_PWM_EN (uses bus.brightness).
module pcileech_led_ctl #(
    parameter int unsigned       NUM_CH            = 6,
    parameter int unsigned       STRETCH_CYCLES    = 5000000,
    parameter int unsigned       BLINK_HALF_CYCLES = 25000000,
    parameter logic [NUM_CH-1:0] INVERT_MASK       = '0
) (
    input logic               clk,
    input logic               rst_n,
    pcileech_led_ctl_if.slave bus
);
    localparam int unsigned   SW           = $clog2(STRETCH_CYCLES + 1);
    localparam int unsigned   BW           = $clog2(BLINK_HALF_CYCLES + 1);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_ACT   = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        ON_ST,
        GAP
    } act_state_e;

    mode_e             ch_mode [NUM_CH];
    act_state_e        state_q [NUM_CH];
    act_state_e        state_d [NUM_CH];
    logic [SW-1:0]     cnt_q   [NUM_CH];
    logic [SW-1:0]     cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;

    logic [BW-1:0]     blink_cnt_q;
    logic [BW-1:0]     blink_cnt_d;
    logic              phase_q;
    logic              phase_d;
    logic              blink_wrap;

    logic [NUM_CH-1:0] lit;
    logic [NUM_CH-1:0] lit_gated;
    logic [NUM_CH-1:0] led_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_mode[i] = mode_e'(bus.mode[2*i +: 2]);
        end
    end

    // Shared blink square wave; all BLINK channels follow the same phase.
    always_comb begin
        blink_wrap  = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BW'(1);
        phase_d     = phase_q ^ blink_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // Lit values are taken from the next state/phase so the registered pin
    // changes on the same edge that the FSM or blink phase does.
    always_comb begin
        pend_d = pend_q;
        lit    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            if (ch_mode[i] != MODE_ACT) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                pend_d[i]  = 1'b0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (bus.act[i]) begin
                            state_d[i] = ON_ST;
                            cnt_d[i]   = STRETCH_LAST;
                        end
                    end
                    ON_ST: begin
                        if (bus.act[i]) begin
                            pend_d[i] = 1'b1;
                        end
                        if (cnt_q[i] == '0) begin
                            state_d[i] = GAP;
                            cnt_d[i]   = STRETCH_LAST;
                        end else begin
                            cnt_d[i] = cnt_q[i] - SW'(1);
                        end
                    end
                    GAP: begin
                        if (cnt_q[i] == '0) begin
                            if (pend_q[i] || bus.act[i]) begin
                                state_d[i] = ON_ST;
                                cnt_d[i]   = STRETCH_LAST;
                            end else begin
                                state_d[i] = IDLE;
                            end
                            pend_d[i] = 1'b0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - SW'(1);
                            if (bus.act[i]) begin
                                pend_d[i] = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                        pend_d[i]  = 1'b0;
                    end
                endcase
            end

            case (ch_mode[i])
                MODE_OFF:   lit[i] = 1'b0;
                MODE_ON:    lit[i] = 1'b1;
                MODE_ACT:   lit[i] = (state_d[i] == ON_ST);
                MODE_BLINK: lit[i] = phase_d;
                default:    lit[i] = 1'b0;
            endcase
        end
    end

`ifdef PCILEECH_LED_CTL_PWM_EN
    logic [7:0] pwm_cnt_q;
    logic       pwm_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
        end
    end

    assign pwm_on    = (pwm_cnt_q < bus.brightness);
    assign lit_gated = lit & {NUM_CH{pwm_on}};
`else
    assign lit_gated = lit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= INVERT_MASK;
        end else begin
            led_q <= lit_gated ^ INVERT_MASK;
        end
    end

    assign bus.led = led_q;

endmodule

// File: tb/tb_pcileech_led_ctl.sv
// Directed bench for pcileech_led_ctl: reset, idle, activity stretch, blink, mode switching.
// Small parameters (STRETCH_CYCLES=4, BLINK_HALF_CYCLES=8) keep every expectation hand-derivable.
module tb_pcileech_led_ctl;
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned STRETCH = 4;
    localparam int unsigned BLINK   = 8;
    localparam logic [3:0]  INV     = 4'b1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pcileech_led_ctl_if #(.NUM_CH(NUM_CH)) bus ();

    pcileech_led_ctl #(
        .NUM_CH            (NUM_CH),
        .STRETCH_CYCLES    (STRETCH),
        .BLINK_HALF_CYCLES (BLINK),
        .INVERT_MASK       (INV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // One-cycle pulse on act[0]: lit for STRETCH edges, then a STRETCH-cycle gap, then idle.
    task automatic pulse_and_check(input string tag);
        bus.act = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            bus.act = 4'b0000;
            check(tag, 32'(bus.led), (k <= 4) ? 32'h9 : 32'h8);
        end
    endtask

    initial begin
        int highs;
        bus.mode = '0;
        bus.act  = '0;
`ifdef PCILEECH_LED_CTL_PWM_EN
        bus.brightness = 8'd0;
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 32'(bus.led), 32'h8);
        repeat (2) tick();
        rst_n = 1'b1;

        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k % 10 == 0) check("idle_hold", 32'(bus.led), 32'h8);
        end

        // Activity stretch from single pulses; the second pulse proves the FSM returned to IDLE.
        bus.mode = 8'b00_00_00_10;
        tick();
        check("act_quiet", 32'(bus.led), 32'h8);
        pulse_and_check("pulse1");
        pulse_and_check("pulse2");

        // Held act: 4 on / 4 off; release during the 3rd ON_ST yields exactly one more ON_ST.
        bus.act = 4'b0001;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 18) bus.act = 4'b0000;
            check("held_act", 32'(bus.led),
                  (k <= 28 && ((k - 1) % 8) < 4) ? 32'h9 : 32'h8);
        end

        // ACTIVITY -> ON -> ACTIVITY with act low.
        bus.act = 4'b0001;
        tick();
        bus.act = 4'b0000;
        check("sw_lit", 32'(bus.led), 32'h9);
        bus.mode = 8'b00_00_00_01;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("sw_on", 32'(bus.led), 32'h9);
        end
        bus.mode = 8'b00_00_00_10;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("sw_back", 32'(bus.led), 32'h8);
        end
        pulse_and_check("sw_idle");

        // Leaving ACTIVITY mid-stretch aborts it with no pending left behind.
        bus.act = 4'b0001;
        tick();
        bus.act = 4'b0000;
        check("abort_lit", 32'(bus.led), 32'h9);
        bus.mode = 8'b00_00_00_00;
        tick();
        check("abort_off", 32'(bus.led), 32'h8);
        bus.mode = 8'b00_00_00_10;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("abort_quiet", 32'(bus.led), 32'h8);
        end

        // Reset asserted mid-stretch.
        bus.act = 4'b0001;
        tick();
        bus.act = 4'b0000;
        tick();
        check("rst_mid_lit", 32'(bus.led), 32'h9);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", 32'(bus.led), 32'h8);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("rst_no_pend", 32'(bus.led), 32'h8);
        end

        // Blink on ch1/ch2 from a fresh reset; ch3 ON with inverted polarity drives its pin low.
        bus.mode = 8'b01_11_11_00;
        apply_reset();
        for (int k = 1; k <= 24; k++) begin
            tick();
            check("blink", 32'(bus.led), (((k / 8) % 2) == 1) ? 32'h6 : 32'h0);
        end

`ifdef PCILEECH_LED_CTL_PWM_EN
        bus.mode       = 8'b00_00_00_01;
        bus.brightness = 8'd64;
        highs = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (bus.led[0]) highs++;
        end
        check("pwm_64", 32'(highs), 32'd64);
        bus.brightness = 8'd0;
        tick();
        highs = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (bus.led[0]) highs++;
        end
        check("pwm_0", 32'(highs), 32'd0);
`else
        highs = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
